// File: rtl/seq_match_ctrl.sv
// Serial bit-pattern matcher: counts matches of a configurable pattern until a target count.
// Optional macro SEQ_OVERLAP_EN keeps history/fill after a match so matches may overlap.
module seq_match_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             in_valid,
  input  logic             in,
  input  logic             abort,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] hist;
  logic [3:0]       len;
  logic [3:0]       fill;
  logic [CNT_W-1:0] target;

  logic [PAT_W-1:0] hist_shift;
  logic [3:0]       fill_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             cfg_legal;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v < lim) ? v + 4'd1 : lim;
  endfunction

  function automatic logic [PAT_W-1:0] len_mask(input logic [3:0] l);
    logic [PAT_W-1:0] m;
    for (int i = 0; i < PAT_W; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  always_comb begin
    hist_shift = {hist[PAT_W-2:0], in};
    fill_inc   = sat_inc(fill, len);
    cnt_inc    = match_cnt + CNT_W'(1);
    hit        = (fill_inc == len) && (((hist_shift ^ pattern) & len_mask(len)) == '0);
    cfg_legal  = (cfg_len != 4'd0) && (int'(cfg_len) <= PAT_W) && (cfg_target != '0);
  end

  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pattern   <= '0;
      hist      <= '0;
      len       <= 4'd0;
      fill      <= 4'd0;
      target    <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      err       <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_legal) begin
              pattern   <= cfg_pattern;
              len       <= cfg_len;
              target    <= cfg_target;
              hist      <= '0;
              fill      <= 4'd0;
              match_cnt <= '0;
              err       <= 1'b0;
              state     <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          // abort takes priority over a match landing on the same edge
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            hist <= hist_shift;
            fill <= fill_inc;
            if (hit) begin
              match     <= 1'b1;
              match_cnt <= cnt_inc;
`ifdef SEQ_OVERLAP_EN
`else
              fill      <= 4'd0;
`endif
              if (cnt_inc == target) begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl; expectations adapt to whether SEQ_OVERLAP_EN is defined.
module tb_seq_match_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [3:0]       cfg_len = 4'd0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic             in_valid = 1'b0;
  logic             din = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
    .in_valid(in_valid), .in(din), .abort(abort), .busy(busy), .match(match),
    .match_cnt(match_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic configure(input logic [7:0] pat, input logic [3:0] l, input logic [7:0] tgt);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = l; cfg_target = tgt;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic v, input logic b, input logic a);
    @(negedge clk);
    in_valid = v; din = b; abort = a;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic go_idle();
    send(1'b0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1 || match !== 1'b0 || done !== 1'b0 ||
        match_cnt !== 8'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b ready=%b match=%b done=%b cnt=%0d err=%b, want 0 1 0 0 0 0",
               busy, cfg_ready, match, done, match_cnt, err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [4:0] bits = 5'b10101;
    logic [4:0] m_got, d_got, m_exp, d_exp;
    logic [7:0] cnt_exp;
`ifdef SEQ_OVERLAP_EN
    m_exp = 5'b10100; d_exp = 5'b10000; cnt_exp = 8'd2;
`else
    m_exp = 5'b00100; d_exp = 5'b00000; cnt_exp = 8'd1;
`endif
    configure(8'b101, 4'd3, 8'd2);
    n_tests++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0 || match_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_accept: busy=%b ready=%b cnt=%0d, want 1 0 0", busy, cfg_ready, match_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      send(1'b1, bits[i], 1'b0);
      m_got[i] = match; d_got[i] = done;
    end
    n_tests++;
    if (m_got !== m_exp) begin
      n_fail++; $display("FAIL basic_match: got %b want %b", m_got, m_exp);
    end
    n_tests++;
    if (d_got !== d_exp || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: done %b busy %b want %b 1", d_got, busy, d_exp);
    end
    go_idle();
    n_tests++;
    if (match_cnt !== cnt_exp || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_cnt_idle: cnt=%0d ready=%b busy=%b want %0d 1 0", match_cnt, cfg_ready, busy, cnt_exp);
    end
  endtask

  task automatic test_overlap_stream();
    logic [7:0] bits = 8'b10110101;
    logic [7:0] m_got, d_got, m_exp, d_exp;
`ifdef SEQ_OVERLAP_EN
    m_exp = 8'b00010100; d_exp = 8'b00010000;
`else
    m_exp = 8'b10000100; d_exp = 8'b10000000;
`endif
    configure(8'b101, 4'd3, 8'd2);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, bits[i], 1'b0);
      m_got[i] = match; d_got[i] = done;
    end
    n_tests++;
    if (m_got !== m_exp) begin
      n_fail++; $display("FAIL stream_match: got %b want %b", m_got, m_exp);
    end
    n_tests++;
    if (d_got !== d_exp) begin
      n_fail++; $display("FAIL stream_done: got %b want %b", d_got, d_exp);
    end
    go_idle();
    n_tests++;
    if (match_cnt !== 8'd2 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL stream_cnt: cnt=%0d ready=%b want 2 1", match_cnt, cfg_ready);
    end
  endtask

  task automatic test_illegal_cfg();
    configure(8'b101, 4'd0, 8'd1);
    n_tests++;
    if (err !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL cfg_len0: err=%b ready=%b busy=%b cnt=%0d want 1 1 0 2", err, cfg_ready, busy, match_cnt);
    end
    configure(8'b101, 4'd9, 8'd1);
    n_tests++;
    if (err !== 1'b1 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL cfg_len9: err=%b ready=%b want 1 1", err, cfg_ready);
    end
    configure(8'b101, 4'd3, 8'd0);
    n_tests++;
    if (err !== 1'b1 || cfg_ready !== 1'b1 || match_cnt !== 8'd2) begin
      n_fail++; $display("FAIL cfg_tgt0: err=%b ready=%b cnt=%0d want 1 1 2", err, cfg_ready, match_cnt);
    end
    configure(8'b101, 4'd3, 8'd1);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL cfg_legal: err=%b busy=%b cnt=%0d want 0 1 0", err, busy, match_cnt);
    end
    go_idle();
  endtask

  task automatic test_full_len();
    logic [7:0] pat = 8'hA5;
    logic [7:0] m_got, d_got;
    configure(pat, 4'd8, 8'd1);
    for (int i = 7; i >= 0; i--) begin
      send(1'b1, pat[i], 1'b0);
      m_got[i] = match; d_got[i] = done;
    end
    n_tests++;
    if (m_got !== 8'b00000001 || d_got !== 8'b00000001 || match_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL full_len: match %b done %b cnt %0d want 00000001 00000001 1", m_got, d_got, match_cnt);
    end
    go_idle();
  endtask

  task automatic test_gaps();
    logic [8:0] vld  = 9'b110100101;
    logic [8:0] bits = 9'b101111011;
    logic [8:0] m_got, d_got, m_exp, d_exp;
`ifdef SEQ_OVERLAP_EN
    m_exp = 9'b100100000; d_exp = 9'b100000000;
`else
    m_exp = 9'b000100000; d_exp = 9'b000000000;
`endif
    configure(8'b101, 4'd3, 8'd2);
    for (int i = 0; i < 9; i++) begin
      send(vld[i], bits[i], 1'b0);
      m_got[i] = match; d_got[i] = done;
    end
    n_tests++;
    if (m_got !== m_exp) begin
      n_fail++; $display("FAIL gaps_match: got %b want %b", m_got, m_exp);
    end
    n_tests++;
    if (d_got !== d_exp) begin
      n_fail++; $display("FAIL gaps_done: got %b want %b", d_got, d_exp);
    end
    go_idle();
  endtask

  task automatic test_abort();
    logic [5:0] bits = 6'b101101;
    logic [5:0] m_got, d_got;
    configure(8'b101, 4'd3, 8'd2);
    for (int i = 0; i < 6; i++) begin
      send(1'b1, bits[i], (i == 5));
      m_got[i] = match; d_got[i] = done;
    end
    n_tests++;
    if (m_got !== 6'b000100 || d_got !== 6'b000000) begin
      n_fail++; $display("FAIL abort_pulses: match %b done %b want 000100 000000", m_got, d_got);
    end
    n_tests++;
    if (match_cnt !== 8'd1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: cnt=%0d ready=%b busy=%b want 1 1 0", match_cnt, cfg_ready, busy);
    end
  endtask

  task automatic test_async_reset();
    configure(8'b101, 4'd3, 8'd3);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (match !== 1'b1 || match_cnt !== 8'd1) begin
      n_fail++; $display("FAIL pre_reset: match=%b cnt=%0d want 1 1", match, match_cnt);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (match !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd0 || busy !== 1'b0 ||
        cfg_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: match=%b done=%b cnt=%0d busy=%b ready=%b err=%b want 0 0 0 0 1 0",
               match, done, match_cnt, busy, cfg_ready, err);
    end
    @(negedge clk);
    reset = 1'b0;
    cfg_valid = 1'b1; cfg_pattern = 8'b101; cfg_len = 4'd3; cfg_target = 8'd1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL first_edge_cfg: busy=%b ready=%b want 1 0", busy, cfg_ready);
    end
    go_idle();
    configure(8'b101, 4'd0, 8'd1);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_reset: err=%b want 0", err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap_stream();
    test_illegal_cfg();
    test_full_len();
    test_gaps();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_match_ctrl.md
SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits and width of cfg_pattern.
REQ-002 Parameter CNT_W, default 8: width of cfg_target and match_cnt.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cfg_valid  input  1  configuration request.
REQ-006 cfg_ready  output  1  configuration accept; high only in IDLE.
REQ-007 cfg_pattern  input  PAT_W  target bit pattern; LSB is the most recent bit.
REQ-008 cfg_len  input  4  pattern length; legal range 1..PAT_W.
REQ-009 cfg_target  input  CNT_W  match count that ends the run; legal range 1..2^CNT_W-1.
REQ-010 in_valid  input  1  qualifies in.
REQ-011 in  input  1  serial data bit.
REQ-012 abort  input  1  terminates a run.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 match  output  1  registered one-cycle pulse per detected pattern.
REQ-015 match_cnt  output  CNT_W  matches counted in the current or last run.
REQ-016 done  output  1  registered one-cycle pulse when match_cnt reaches the target.
REQ-017 err  output  1  sticky illegal-configuration flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 In IDLE, cfg_valid&&cfg_ready SHALL accept a configuration at that edge; a legal configuration latches pattern, length and target, clears history, the history fill count, match_cnt and err, and moves to RUN.
REQ-020 An illegal configuration (cfg_len==0, cfg_len>PAT_W, or cfg_target==0) SHALL set err=1, keep the state at IDLE and leave match_cnt unchanged.
REQ-021 In RUN, each edge with in_valid=1 SHALL shift the history register ({hist[PAT_W-2:0],in}) and SATURATE the fill count at cfg_len; edges with in_valid=0 leave the history unchanged.
REQ-022 A match SHALL occur when, after the shift, fill==len and the low len bits of the history equal the low len bits of the pattern.
REQ-023 On a match, at the same edge: match<=1 for exactly one cycle and match_cnt<=match_cnt+1, giving a latency of one cycle from the sampling edge.
REQ-024 When the incremented match_cnt equals the target, the FSM SHALL go to DONE; done SHALL be 1 for that single cycle, coincident with the final match pulse, and the FSM returns to IDLE on the next edge.
REQ-025 abort in RUN SHALL return the FSM to IDLE at that edge with no match, done or count update; if abort and a match occur on the same edge, abort wins.
REQ-026 in_valid, in and abort SHALL be ignored in IDLE and DONE; cfg_valid SHALL be ignored outside IDLE.
REQ-027 match_cnt SHALL hold its value in IDLE until the next legal configuration is accepted.

Reset
REQ-028 Asserting reset SHALL immediately force state=IDLE, history=0, fill=0, match=0, done=0, match_cnt=0, err=0, busy=0 and cfg_ready=1, including in the middle of a run.
REQ-029 The first edge after reset deassertion SHALL already accept a configuration.

Configuration
REQ-030 Macro SEQ_OVERLAP_EN: when it is defined, the history and fill count SHALL be retained after a match, so matches may overlap.
REQ-031 When SEQ_OVERLAP_EN is undefined, the fill count SHALL clear to 0 on every match (non-overlapping detection).

Verification
REQ-032 Test 1: pattern 3'b101, len 3, target 2, overlap on; stream 1,0,1,0,1 -> match after bits 3 and 5; done with the 5th-bit match; match_cnt=2.
REQ-033 Test 2: same configuration, overlap off; stream 1,0,1,0,1,1,0,1 -> matches after bits 3 and 8 only; done after bit 8.
REQ-034 Test 3: cfg_len=0 -> err=1, cfg_ready stays 1; then a legal configuration -> err=0 and busy=1.
REQ-035 Test 4: in_valid=0 gaps inserted between the bits of Test 1 -> identical match and done sequence, each delayed by the gaps.
REQ-036 Test 5: abort on the same edge as the 2nd match -> no match or done pulse, match_cnt=1, state IDLE.
REQ-037 Test 6: reset asserted mid-RUN, asynchronously between edges -> all outputs take their reset values immediately; the next configuration is accepted on the first edge after reset is released.
